coffee_plant_model: RTL and testbench

- Sequential plant model of the coffee machine hardware, the other end of the controller's sensor/actuator interface.
- Consumes the controller's actuator commands (P, AQ, PP, M) and produces its sensor inputs (SR, SP, SN, A, VL).
- Models reservoir depletion, water heating and cooling, and a debounced cup switch.
- Used for closed-loop simulation of the controller and for on-board demos with switches as refill and cup inputs.

---
 rtl/coffee_plant_if.sv | 34 +++
 rtl/coffee_plant_model.sv | 152 +++++++++++++++
 tb/tb_coffee_plant_model.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/coffee_plant_if.sv
// Sensor/actuator bundle between the coffee controller (master) and the plant model (slave).
interface coffee_plant_if #(
    parameter int LEVEL_W = 4,
    parameter int TEMP_W  = 5
);
    logic               P;
    logic               PP;
    logic               M;
    logic               AQ;
    logic               refill_r;
    logic               refill_p;
    logic               refill_n;
    logic               cup_sw;
    logic               SR;
    logic               SP;
    logic               SN;
    logic               A;
    logic               VL;
    logic [LEVEL_W-1:0] level_r;
    logic [LEVEL_W-1:0] level_p;
    logic [LEVEL_W-1:0] level_n;
    logic [TEMP_W-1:0]  temp;

    // Level-sensitive interface: commands are sampled every rising edge, no valid/ready handshake.
    modport master (
        output P, PP, M, AQ, refill_r, refill_p, refill_n, cup_sw,
        input  SR, SP, SN, A, VL, level_r, level_p, level_n, temp
    );

    modport slave (
        input  P, PP, M, AQ, refill_r, refill_p, refill_n, cup_sw,
        output SR, SP, SN, A, VL, level_r, level_p, level_n, temp
    );
endinterface

// File: rtl/coffee_plant_model.sv
// Plant model of the coffee machine: reservoirs, heater and debounced cup switch.
// Every output is a flop; sensors are computed from next-state values.
module coffee_plant_model #(
    parameter int LEVEL_W    = 4,
    parameter int DOSE       = 3,
    parameter int HEAT_MAX   = 20,
    parameter int COOL_DIV   = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    coffee_plant_if.slave bus
);
    localparam int TEMP_W = $clog2(HEAT_MAX + 1);
    localparam int PRE_W  = $clog2(COOL_DIV + 1);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);

    localparam logic [LEVEL_W-1:0] FULL    = '1;
    localparam logic [LEVEL_W-1:0] DOSE_L  = LEVEL_W'(DOSE);
    localparam logic [TEMP_W-1:0]  HMAX    = TEMP_W'(HEAT_MAX);
    localparam logic [TEMP_W-1:0]  HALF    = TEMP_W'(HEAT_MAX / 2);
    localparam logic [PRE_W-1:0]   PRE_TOP = PRE_W'(COOL_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_TOP = DEB_W'(DEB_CYCLES - 1);

    // Edge-detect history plus an arm flag: a command held through reset
    // must be seen low once before its next rising edge is honoured.
    logic hist_p, hist_r, hist_m;
    logic arm_p, arm_r, arm_m;
    logic edge_p, edge_r, edge_m;

    logic [LEVEL_W-1:0] lvl_r_q, lvl_p_q, lvl_n_q;
    logic [LEVEL_W-1:0] lvl_r_d, lvl_p_d, lvl_n_d;

    logic [TEMP_W-1:0] temp_q, temp_d, temp_heat;
    logic [PRE_W-1:0]  pre_q, pre_d;

    logic              sync1, sync2;
    logic [DEB_W-1:0]  deb_q;
    logic              vl_q;

    logic sr_q, sp_q, sn_q, a_q;

    function automatic logic [LEVEL_W-1:0] level_next(
        input logic [LEVEL_W-1:0] lvl,
        input logic               refill,
        input logic               take
    );
        if (refill)
            return FULL;
        else if (take)
            return (lvl >= DOSE_L) ? (lvl - DOSE_L) : '0;
        else
            return lvl;
    endfunction

    always_comb begin
        edge_p = bus.P  & ~hist_p & arm_p;
        edge_r = bus.PP & ~hist_r & arm_r;
        edge_m = bus.M  & ~hist_m & arm_m;

        lvl_p_d = level_next(lvl_p_q, bus.refill_p, edge_p);
        lvl_r_d = level_next(lvl_r_q, bus.refill_r, edge_r);
        lvl_n_d = level_next(lvl_n_q, bus.refill_n, edge_m);

        temp_heat = temp_q;
        pre_d     = '0;
        if (bus.AQ) begin
            if (temp_q != HMAX)
                temp_heat = temp_q + 1'b1;
        end else if (pre_q == PRE_TOP) begin
            if (temp_q != '0)
                temp_heat = temp_q - 1'b1;
        end else begin
            pre_d = pre_q + 1'b1;
        end

        // Hot-water draw applies after heating/cooling in the same cycle.
        temp_d = temp_heat;
        if (edge_m)
            temp_d = (temp_heat >= HALF) ? (temp_heat - HALF) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hist_p  <= 1'b0;
            hist_r  <= 1'b0;
            hist_m  <= 1'b0;
            arm_p   <= 1'b0;
            arm_r   <= 1'b0;
            arm_m   <= 1'b0;
            lvl_p_q <= FULL;
            lvl_r_q <= FULL;
            lvl_n_q <= FULL;
            sp_q    <= 1'b1;
            sr_q    <= 1'b1;
            sn_q    <= 1'b1;
            temp_q  <= '0;
            pre_q   <= '0;
            a_q     <= 1'b0;
        end else begin
            hist_p  <= bus.P;
            hist_r  <= bus.PP;
            hist_m  <= bus.M;
            arm_p   <= arm_p | ~bus.P;
            arm_r   <= arm_r | ~bus.PP;
            arm_m   <= arm_m | ~bus.M;
            lvl_p_q <= lvl_p_d;
            lvl_r_q <= lvl_r_d;
            lvl_n_q <= lvl_n_d;
            sp_q    <= (lvl_p_d >= DOSE_L);
            sr_q    <= (lvl_r_d >= DOSE_L);
            sn_q    <= (lvl_n_d >= DOSE_L);
            temp_q  <= temp_d;
            pre_q   <= pre_d;
            a_q     <= (temp_d == HMAX);
        end
    end

    // Cup switch: two-flop synchronizer, then accept a change only after
    // DEB_CYCLES consecutive differing samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb_q <= '0;
            vl_q  <= 1'b0;
        end else begin
            sync1 <= bus.cup_sw;
            sync2 <= sync1;
            if (sync2 != vl_q) begin
                if (deb_q == DEB_TOP) begin
                    vl_q  <= sync2;
                    deb_q <= '0;
                end else begin
                    deb_q <= deb_q + 1'b1;
                end
            end else begin
                deb_q <= '0;
            end
        end
    end

    assign bus.SR      = sr_q;
    assign bus.SP      = sp_q;
    assign bus.SN      = sn_q;
    assign bus.A       = a_q;
    assign bus.VL      = vl_q;
    assign bus.level_r = lvl_r_q;
    assign bus.level_p = lvl_p_q;
    assign bus.level_n = lvl_n_q;
    assign bus.temp    = temp_q;
endmodule

// File: tb/tb_coffee_plant_model.sv
// Directed bench for coffee_plant_model with default parameters (full=15, DOSE=3, HEAT_MAX=20).
module tb_coffee_plant_model;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    coffee_plant_if #(.LEVEL_W(4), .TEMP_W(5)) bus();

    coffee_plant_model #(
        .LEVEL_W(4), .DOSE(3), .HEAT_MAX(20), .COOL_DIV(8), .DEB_CYCLES(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
        repeat (5) step();
        n_checks++;
        if (bus.level_r !== 4'd15 || bus.level_p !== 4'd15 || bus.level_n !== 4'd15) begin
            n_fail++;
            $display("FAIL reset_levels: got r=%0d p=%0d n=%0d want 15 15 15", bus.level_r, bus.level_p, bus.level_n);
        end
        n_checks++;
        if ({bus.SR, bus.SP, bus.SN, bus.A, bus.VL} !== 5'b11100) begin
            n_fail++;
            $display("FAIL reset_flags: got SR,SP,SN,A,VL=%b want 11100", {bus.SR, bus.SP, bus.SN, bus.A, bus.VL});
        end
        n_checks++;
        if (bus.temp !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_temp: got %0d want 0", bus.temp);
        end
    endtask

    task automatic test_dispense_p();
        logic [3:0] exp_lvl [6] = '{4'd12, 4'd9, 4'd6, 4'd3, 4'd0, 4'd0};
        logic       exp_sp  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            bus.P = 1'b1;
            step();
            n_checks++;
            if (bus.level_p !== exp_lvl[i] || bus.SP !== exp_sp[i]) begin
                n_fail++;
                $display("FAIL dispense_p[%0d]: got level=%0d SP=%b want level=%0d SP=%b",
                         i, bus.level_p, bus.SP, exp_lvl[i], exp_sp[i]);
            end
            bus.P = 1'b0;
            step();
        end
    endtask

    task automatic test_hold_and_refill();
        bus.PP = 1'b1;
        repeat (10) step();
        n_checks++;
        if (bus.level_r !== 4'd12 || bus.SR !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_pp: got level_r=%0d SR=%b want 12 1", bus.level_r, bus.SR);
        end
        bus.PP = 1'b0;
        step();
        bus.PP       = 1'b1;
        bus.refill_r = 1'b1;
        step();
        n_checks++;
        if (bus.level_r !== 4'd15 || bus.SR !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_wins: got level_r=%0d SR=%b want 15 1", bus.level_r, bus.SR);
        end
        bus.PP       = 1'b0;
        bus.refill_r = 1'b0;
        step();
        // Refill P from the empty state left by the dispense test.
        bus.refill_p = 1'b1;
        step();
        bus.refill_p = 1'b0;
        n_checks++;
        if (bus.level_p !== 4'd15 || bus.SP !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_p: got level_p=%0d SP=%b want 15 1", bus.level_p, bus.SP);
        end
    endtask

    task automatic test_heater();
        int exp_t;
        bus.AQ = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step();
            exp_t = (i > 20) ? 20 : i;
            n_checks++;
            if (bus.temp !== 5'(exp_t) || bus.A !== (exp_t == 20)) begin
                n_fail++;
                $display("FAIL heat[%0d]: got temp=%0d A=%b want temp=%0d A=%b",
                         i, bus.temp, bus.A, exp_t, (exp_t == 20));
            end
        end
        bus.M = 1'b1;
        step();
        n_checks++;
        if (bus.temp !== 5'd10 || bus.A !== 1'b0 || bus.level_n !== 4'd12) begin
            n_fail++;
            $display("FAIL draw: got temp=%0d A=%b level_n=%0d want 10 0 12", bus.temp, bus.A, bus.level_n);
        end
        bus.M  = 1'b0;
        bus.AQ = 1'b0;
        repeat (8) step();
        n_checks++;
        if (bus.temp !== 5'd9) begin
            n_fail++;
            $display("FAIL cool8: got temp=%0d want 9", bus.temp);
        end
        repeat (8) step();
        n_checks++;
        if (bus.temp !== 5'd8) begin
            n_fail++;
            $display("FAIL cool16: got temp=%0d want 8", bus.temp);
        end
    endtask

    task automatic test_reset_mid_dispense();
        // Bring level_r 15->9 and temp 8->12, ending with PP held at level_r=6.
        bus.AQ = 1'b1; bus.PP = 1'b1; step();
        bus.PP = 1'b0; step();
        bus.PP = 1'b1; step();
        bus.PP = 1'b0; step();
        bus.AQ = 1'b0; bus.PP = 1'b1; step();
        n_checks++;
        if (bus.level_r !== 4'd6 || bus.temp !== 5'd12) begin
            n_fail++;
            $display("FAIL pre_reset: got level_r=%0d temp=%0d want 6 12", bus.level_r, bus.temp);
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        n_checks++;
        if (bus.level_r !== 4'd15 || bus.level_n !== 4'd15 || bus.temp !== 5'd0 || bus.A !== 1'b0 || bus.SR !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got level_r=%0d level_n=%0d temp=%0d A=%b SR=%b want 15 15 0 0 1",
                     bus.level_r, bus.level_n, bus.temp, bus.A, bus.SR);
        end
        repeat (3) step();
        n_checks++;
        if (bus.level_r !== 4'd15) begin
            n_fail++;
            $display("FAIL held_after_reset: got level_r=%0d want 15", bus.level_r);
        end
        bus.PP = 1'b0; step();
        bus.PP = 1'b1; step();
        n_checks++;
        if (bus.level_r !== 4'd12) begin
            n_fail++;
            $display("FAIL rearm: got level_r=%0d want 12", bus.level_r);
        end
        bus.PP = 1'b0; step();
    endtask

    task automatic test_cup_debounce();
        for (int i = 0; i < 20; i++) begin
            bus.cup_sw = ((i / 2) % 2 == 0);
            step();
            n_checks++;
            if (bus.VL !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch[%0d]: got VL=%b want 0", i, bus.VL);
            end
        end
        bus.cup_sw = 1'b0;
        repeat (4) step();
        bus.cup_sw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            n_checks++;
            if (bus.VL !== (i >= 6)) begin
                n_fail++;
                $display("FAIL cup_latency[%0d]: got VL=%b want %b", i, bus.VL, (i >= 6));
            end
        end
    endtask

    initial begin
        bus.P = 1'b0; bus.PP = 1'b0; bus.M = 1'b0; bus.AQ = 1'b0;
        bus.refill_r = 1'b0; bus.refill_p = 1'b0; bus.refill_n = 1'b0;
        bus.cup_sw = 1'b0;
        test_reset();
        test_dispense_p();
        test_hold_and_refill();
        test_heater();
        test_reset_mid_dispense();
        test_cup_debounce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
